// File: rtl/aes_cipher_sched_if.sv
// aes_cipher_sched_if: requester handshake, credit return, response and core-side signals of the AES cipher scheduler
interface aes_cipher_sched_if #(
  parameter int NREQ = 4,
  parameter int NKB  = 128
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*NKB-1:0] req_in;
  logic [NREQ*NKB-1:0] req_key;
  logic [NREQ-1:0]     cred_ret;
  logic                core_rst_n;
  logic                core_valid_in;
  logic [NKB-1:0]      core_in;
  logic [NKB-1:0]      core_key;
  logic                core_valid_out;
  logic [NKB-1:0]      core_out;
  logic [NREQ-1:0]     rsp_valid;
  logic [NKB-1:0]      rsp_data;
  logic                busy;
  logic                err_sync;
  modport slave (
    input  req_valid, req_in, req_key, cred_ret, core_valid_out, core_out,
    output req_ready, rsp_valid, rsp_data, busy, err_sync, core_rst_n, core_valid_in, core_in, core_key
  );
  modport master (
    output req_valid, req_in, req_key, cred_ret, core_valid_out, core_out,
    input  req_ready, rsp_valid, rsp_data, busy, err_sync, core_rst_n, core_valid_in, core_in, core_key
  );
endinterface

// File: rtl/aes_cipher_sched.sv
// aes_cipher_sched: round-robin, credit-limited sharing of one pipelined AES core; ports clk, rst, bus (requesters, credits, core, responses)
module aes_cipher_sched #(
  parameter int NREQ    = 4,
  parameter int NKB     = 128,
  parameter int LAT     = 11,
  parameter int CREDITS = 4
) (
  input logic clk,
  input logic rst,
  aes_cipher_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  logic [3:0]    credit [NREQ];
  logic [IW-1:0] rr_ptr, gid;
  logic          hs;
  logic [LAT:0]  tag_v;
  logic [IW-1:0] tag_id [LAT+1];
  int            j;
  always_comb begin
    hs  = 1'b0;
    gid = '0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!rst && bus.req_valid[j] && credit[j] != 4'd0) begin
        hs  = 1'b1;
        gid = IW'(j);
      end
    end
  end
  assign bus.req_ready  = hs ? NREQ'(1) << gid : '0;
  assign bus.core_rst_n = ~rst;
  assign bus.busy       = (|tag_v) | (|bus.rsp_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr            <= '0;
      tag_v             <= '0;
      bus.core_valid_in <= 1'b0;
      bus.core_in       <= '0;
      bus.core_key      <= '0;
      bus.rsp_valid     <= '0;
      bus.rsp_data      <= '0;
      bus.err_sync      <= 1'b0;
      for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
      for (int i = 0; i < NREQ; i++) credit[i] <= 4'(CREDITS);
    end else begin
      bus.core_valid_in <= hs;
      if (hs) begin
        bus.core_in  <= bus.req_in[int'(gid)*NKB +: NKB];
        bus.core_key <= bus.req_key[int'(gid)*NKB +: NKB];
        rr_ptr       <= IW'((int'(gid) + 1) % NREQ);
      end
      tag_v     <= {tag_v[LAT-1:0], hs};
      tag_id[0] <= gid;
      for (int i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
      bus.rsp_valid <= (tag_v[LAT] && bus.core_valid_out) ? NREQ'(1) << tag_id[LAT] : '0;
      if (tag_v[LAT] && bus.core_valid_out) bus.rsp_data <= bus.core_out;
      bus.err_sync <= bus.err_sync | (tag_v[LAT] != bus.core_valid_out);
      for (int i = 0; i < NREQ; i++)
        credit[i] <= (hs && gid == IW'(i) && !bus.cred_ret[i]) ? credit[i] - 4'd1 :
                     (bus.cred_ret[i] && !(hs && gid == IW'(i)) && credit[i] != 4'(CREDITS)) ? credit[i] + 4'd1 :
                     credit[i];
    end
  end
endmodule

// File: tb/tb_aes_cipher_sched.sv
// tb_aes_cipher_sched: scoreboard bench for aes_cipher_sched with a behavioural fixed-latency core model
module tb_aes_cipher_sched;
  localparam int NREQ = 4, NKB = 128, LAT = 11, CR = 4;
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0, rst = 1, force_cv = 0;
  always #5 clk = ~clk;
  aes_cipher_sched_if #(.NREQ(NREQ), .NKB(NKB)) bus();
  aes_cipher_sched #(.NREQ(NREQ), .NKB(NKB), .LAT(LAT), .CREDITS(CR)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  function automatic logic [127:0] f(input logic [127:0] p, input logic [127:0] k);
    return (p == C1P && k == C1K) ? C1C : p ^ {k[63:0], k[127:64]} ^ 128'h5a;
  endfunction
  logic [LAT-1:0] pv;
  logic [127:0]   pd [LAT];
  always @(posedge clk) begin
    if (!bus.core_rst_n) pv <= '0;
    else begin
      pv    <= {pv[LAT-2:0], bus.core_valid_in};
      pd[0] <= f(bus.core_in, bus.core_key);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end
  assign bus.core_valid_out = pv[LAT-1] | force_cv;
  assign bus.core_out       = pd[LAT-1];
  typedef struct {int id; logic [127:0] d; int cyc;} exp_t;
  typedef struct {logic [3:0] v; logic [127:0] d; int cyc;} got_t;
  exp_t exp_q[$];
  got_t got_q[$];
  int gnt_q[$], gcyc_q[$];
  int cyc = 0, cv_cnt = 0, n_cmp = 0, n_err = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    for (int i = 0; i < NREQ; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        exp_q.push_back('{i, f(bus.req_in[i*NKB +: NKB], bus.req_key[i*NKB +: NKB]), cyc + LAT + 2});
        gnt_q.push_back(i);
        gcyc_q.push_back(cyc);
      end
    if (bus.rsp_valid != 0) got_q.push_back('{bus.rsp_valid, bus.rsp_data, cyc});
    if (bus.core_valid_in) cv_cnt++;
  end
  task automatic tick; @(posedge clk); #1; endtask
  task automatic sample; @(negedge clk); endtask
  task automatic ticks(input int n); for (int i = 0; i < n; i++) tick; endtask
  task automatic do_reset;
    rst = 1; bus.req_valid = '0; bus.cred_ret = '0; force_cv = 0;
    ticks(2);
    rst = 0;
    exp_q.delete(); got_q.delete(); gnt_q.delete(); gcyc_q.delete();
  endtask
  task automatic test_reset;
    rst = 1; bus.req_valid = '1; bus.cred_ret = '0;
    tick;
    sample;
    n_cmp++; if (bus.req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready got %h exp 0", bus.req_ready); end
    n_cmp++; if (bus.core_valid_in !== 1'b0) begin n_err++; $display("FAIL reset_cvi got %b exp 0", bus.core_valid_in); end
    n_cmp++; if (bus.core_in !== '0 || bus.core_key !== '0) begin n_err++; $display("FAIL reset_core got %h/%h exp 0", bus.core_in, bus.core_key); end
    n_cmp++; if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp got %h/%h exp 0", bus.rsp_valid, bus.rsp_data); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.err_sync !== 1'b0) begin n_err++; $display("FAIL reset_flags got busy %b err %b exp 0", bus.busy, bus.err_sync); end
    n_cmp++; if (bus.core_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_core_rst_n got %b exp 0", bus.core_rst_n); end
    do_reset;
  endtask
  task automatic test_single;
    exp_t e; got_t g;
    do_reset;
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = '0;
    sample;
    n_cmp++; if (bus.core_valid_in !== 1'b1 || bus.core_in !== C1P || bus.core_key !== C1K) begin n_err++; $display("FAIL single_issue got %b %h %h exp 1 %h %h", bus.core_valid_in, bus.core_in, bus.core_key, C1P, C1K); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", bus.busy); end
    for (int t = 0; t < 40 && got_q.size() < 1; t++) sample;
    n_cmp++; if (got_q.size() != 1 || exp_q.size() != 1) begin n_err++; $display("FAIL single_count got %0d rsp %0d exp, need 1/1", got_q.size(), exp_q.size()); end
    else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g.v !== 4'b0001) begin n_err++; $display("FAIL single_valid got %b exp 0001", g.v); end
      n_cmp++; if (g.d !== C1C) begin n_err++; $display("FAIL single_data got %h exp %h", g.d, C1C); end
      n_cmp++; if (g.cyc != e.cyc) begin n_err++; $display("FAIL single_latency got cycle %0d exp %0d", g.cyc, e.cyc); end
    end
    sample;
    n_cmp++; if (bus.rsp_valid !== 4'b0 || bus.rsp_data !== C1C) begin n_err++; $display("FAIL single_hold got %b %h exp 0 %h", bus.rsp_valid, bus.rsp_data, C1C); end
  endtask
  task automatic test_all_four;
    exp_t e; got_t g; int cv0;
    do_reset;
    cv0 = cv_cnt;
    bus.req_valid = '1;
    for (int t = 0; t < 40 && gnt_q.size() < 16; t++) sample;
    ticks(2);
    sample;
    n_cmp++; if (bus.req_ready !== 4'b0 || gnt_q.size() != 16) begin n_err++; $display("FAIL four_stall got ready %b grants %0d exp 0 16", bus.req_ready, gnt_q.size()); end
    n_cmp++; if (cv_cnt - cv0 != 16) begin n_err++; $display("FAIL four_cvi got %0d exp 16", cv_cnt - cv0); end
    for (int k = 0; k < 16 && k < gnt_q.size(); k++) begin
      n_cmp++; if (gnt_q[k] != k % 4 || gcyc_q[k] != gcyc_q[0] + k) begin n_err++; $display("FAIL four_grant%0d got id %0d cyc %0d exp %0d %0d", k, gnt_q[k], gcyc_q[k], k % 4, gcyc_q[0] + k); end
    end
    for (int t = 0; t < 60 && got_q.size() < 16; t++) sample;
    n_cmp++; if (got_q.size() != 16) begin n_err++; $display("FAIL four_rsp_count got %0d exp 16", got_q.size()); end
    for (int k = 0; k < 16 && got_q.size() > 0 && exp_q.size() > 0; k++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (g.v !== 4'(1 << (k % 4)) || g.v !== 4'(1 << e.id) || g.d !== e.d || g.cyc != e.cyc) begin n_err++; $display("FAIL four_rsp%0d got %b %h c%0d exp %b %h c%0d", k, g.v, g.d, g.cyc, 4'(1 << e.id), e.d, e.cyc); end
    end
    bus.cred_ret = '1;
    tick;
    bus.cred_ret = '0;
    for (int t = 0; t < 20 && gnt_q.size() < 20; t++) sample;
    bus.req_valid = '0;
    n_cmp++; if (gnt_q.size() != 20) begin n_err++; $display("FAIL four_regrant_count got %0d exp 20", gnt_q.size()); end
    for (int k = 16; k < gnt_q.size() && k < 20; k++) begin
      n_cmp++; if (gnt_q[k] != k - 16) begin n_err++; $display("FAIL four_regrant%0d got %0d exp %0d", k, gnt_q[k], k - 16); end
    end
  endtask
  task automatic test_credits;
    do_reset;
    bus.req_valid = 4'b0100;
    ticks(20);
    sample;
    n_cmp++; if (gnt_q.size() != CR || bus.req_ready !== 4'b0) begin n_err++; $display("FAIL cred_exhaust got %0d ready %b exp %0d 0", gnt_q.size(), bus.req_ready, CR); end
    bus.cred_ret = 4'b0100;
    tick;
    bus.cred_ret = '0;
    ticks(6);
    sample;
    n_cmp++; if (gnt_q.size() != CR + 1 || bus.req_ready !== 4'b0) begin n_err++; $display("FAIL cred_one_return got %0d ready %b exp %0d 0", gnt_q.size(), bus.req_ready, CR + 1); end
    bus.req_valid = '0;
    bus.cred_ret = 4'b0100;
    ticks(2);
    bus.req_valid = 4'b0100;
    tick;
    bus.cred_ret = '0;
    ticks(6);
    sample;
    n_cmp++; if (gnt_q.size() != CR + 4) begin n_err++; $display("FAIL cred_coincident got %0d exp %0d", gnt_q.size(), CR + 4); end
    do_reset;
    bus.cred_ret = 4'b0100;
    ticks(3);
    bus.cred_ret = '0;
    bus.req_valid = 4'b0100;
    ticks(10);
    sample;
    n_cmp++; if (gnt_q.size() != CR) begin n_err++; $display("FAIL cred_saturate got %0d exp %0d", gnt_q.size(), CR); end
    bus.req_valid = '0;
  endtask
  task automatic test_reset_midflight;
    do_reset;
    bus.req_valid = 4'b0111;
    ticks(3);
    bus.req_valid = '0;
    n_cmp++; if (gnt_q.size() != 3) begin n_err++; $display("FAIL mid_grants got %0d exp 3", gnt_q.size()); end
    ticks(5);
    rst = 1;
    tick;
    rst = 0;
    sample;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
    ticks(20);
    n_cmp++; if (got_q.size() != 0 || bus.err_sync !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp got %0d err %b exp 0 0", got_q.size(), bus.err_sync); end
    gnt_q.delete();
    bus.req_valid = 4'b1010;
    tick;
    bus.req_valid = 4'b0001;
    ticks(12);
    bus.req_valid = '0;
    n_cmp++; if (gnt_q.size() < 1 || gnt_q[0] != 1) begin n_err++; $display("FAIL mid_rrptr got first %0d exp 1", gnt_q.size() > 0 ? gnt_q[0] : -1); end
    n_cmp++; if (gnt_q.size() != 1 + CR) begin n_err++; $display("FAIL mid_credits got %0d grants exp %0d", gnt_q.size(), 1 + CR); end
  endtask
  task automatic test_sync_fault;
    do_reset;
    force_cv = 1;
    tick;
    force_cv = 0;
    sample;
    n_cmp++; if (bus.err_sync !== 1'b1 || bus.rsp_valid !== 4'b0) begin n_err++; $display("FAIL sync_set got err %b rsp %b exp 1 0", bus.err_sync, bus.rsp_valid); end
    ticks(3);
    sample;
    n_cmp++; if (bus.err_sync !== 1'b1 || bus.rsp_valid !== 4'b0) begin n_err++; $display("FAIL sync_sticky got err %b rsp %b exp 1 0", bus.err_sync, bus.rsp_valid); end
    do_reset;
    sample;
    n_cmp++; if (bus.err_sync !== 1'b0) begin n_err++; $display("FAIL sync_clear got %b exp 0", bus.err_sync); end
  endtask
  task automatic test_wrap;
    do_reset;
    bus.req_valid = 4'b0111;
    ticks(3);
    bus.req_valid = 4'b1001;
    ticks(3);
    bus.req_valid = '0;
    n_cmp++; if (gnt_q.size() != 6) begin n_err++; $display("FAIL wrap_count got %0d exp 6", gnt_q.size()); end
    else begin
      n_cmp++; if (gnt_q[3] != 3 || gnt_q[4] != 0 || gnt_q[5] != 3) begin n_err++; $display("FAIL wrap_order got %0d %0d %0d exp 3 0 3", gnt_q[3], gnt_q[4], gnt_q[5]); end
    end
  endtask
  initial begin
    bus.req_valid = '0;
    bus.cred_ret  = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_in[i*NKB +: NKB]  = C1P;
      bus.req_key[i*NKB +: NKB] = C1K;
    end
    test_reset;
    test_single;
    test_all_four;
    test_credits;
    test_reset_midflight;
    test_sync_fault;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/aes_cipher_sched.md
Name: aes_cipher_sched

Overview:
- Round-robin scheduler that shares one pipelined AES cipher core among NREQ requesters.
- Accepts plaintext/key pairs over per-requester valid/ready and issues at most one block per cycle into the core.
- Tracks the owner of each in-flight block in a tag pipeline matched to the core latency and routes each ciphertext back to its owner.
- Per-requester credit counters bound the number of outstanding results, because the core pipeline cannot stall.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NKB, 128, block/key width in bits.
- LAT, 11, core latency: cycles from core_valid_in high to the matching core_valid_out high.
- CREDITS, 4, maximum outstanding results per requester (1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request present, one bit per requester.
- req_ready  out  NREQ  grant; a handshake occurs when req_valid[i] & req_ready[i].
- req_in  in  NREQ*NKB  plaintext; requester i occupies bits [i*NKB +: NKB].
- req_key  in  NREQ*NKB  key, same packing as req_in.
- cred_ret  in  NREQ  1-cycle pulse: consumer of requester i freed one result slot.
- core_rst_n  out  1  core reset, equal to ~rst (combinational).
- core_valid_in  out  1  registered issue strobe to the core.
- core_in  out  NKB  registered plaintext to the core.
- core_key  out  NKB  registered key to the core.
- core_valid_out  in  1  core result strobe.
- core_out  in  NKB  core ciphertext.
- rsp_valid  out  NREQ  one-hot result strobe, registered.
- rsp_data  out  NKB  ciphertext, registered.
- busy  out  1  high while any tag is in flight or rsp_valid is high.
- err_sync  out  1  sticky: core_valid_out disagreed with the tag pipeline.

Behaviour:
- Reset (rst high at an edge):
  - req_ready=0, core_valid_in=0, core_in=0, core_key=0, rsp_valid=0, rsp_data=0, busy=0, err_sync=0.
  - Tag pipeline cleared; credit[i]=CREDITS; rr_ptr=0.
  - Reset mid-operation discards all in-flight blocks; no rsp_valid is produced for them afterwards.
- Eligibility: eligible[i] = req_valid[i] & (credit[i] != 0).
- Arbitration (combinational):
  - Search starts at rr_ptr and wraps modulo NREQ; the first eligible i gets req_ready[i]=1.
  - At most one req_ready bit is high; none is high during rst.
- On handshake of requester g at edge E:
  - core_valid_in=1, core_in=req_in[g], core_key=req_key[g] in the cycle after E.
  - rr_ptr=(g+1) mod NREQ; credit[g] decrements.
  - The tag {1,g} enters the tag pipeline.
- Without a handshake, core_valid_in=0 and core_in/core_key hold their last values.
- Tag pipeline: LAT+1 stage shift register of {valid,id}, aligned so its head is presented in the same cycle as the matching core_valid_out.
- Response path, every cycle:
  - If head.valid & core_valid_out: next cycle rsp_valid[head.id]=1 and rsp_data=core_out.
  - If head.valid != core_valid_out: err_sync is set; no rsp_valid is produced that cycle.
  - err_sync clears only on rst.
- Latency: handshake edge E to rsp_valid high is LAT+2 cycles. Throughput is 1 block/cycle, back-to-back across any requesters.
- Credits:
  - cred_ret[i] alone increments credit[i], saturating at CREDITS; a return at CREDITS is ignored.
  - cred_ret[i] and a handshake of i in the same cycle leave credit[i] unchanged.
  - When credit[i]==0, requester i is skipped even if req_valid[i] is high.
- Requesters must hold req_in/req_key stable while req_valid is high and unacknowledged.
- rsp_data holds its value when rsp_valid is all zero.

Test Plan:
- Single request, FIPS-197 C.1 vector: req 0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> rsp_valid=0001 exactly LAT+2 cycles after the handshake, rsp_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- All four requesters valid continuously with the C.1 vector:
  - Grants follow 0,1,2,3,0,...; core_valid_in stays high every cycle.
  - rsp_valid one-hot follows the same order.
  - Each requester stalls after 4 grants until cred_ret arrives.
- Credit exhaustion and return: req 2 only, no cred_ret -> exactly CREDITS handshakes, then req_ready[2]=0. One cred_ret[2] pulse -> exactly one more grant. cred_ret coincident with a handshake -> credit unchanged.
- Reset mid-flight: rst for 1 cycle 5 cycles after 3 handshakes -> no rsp_valid for those blocks, credits back to 4, rr_ptr=0, busy=0 one cycle after reset.
- Sync fault: force core_valid_out=1 with an empty tag pipeline -> err_sync=1 next cycle and stays 1, rsp_valid remains 0.
- Boundary arbitration: rr_ptr=3 with only req 0 and req 3 valid -> grant 3, then 0, then 3 (wrap-around).
